// File: rtl/cnt_seq_checker.sv
// Watches the output of a free-running binary up-counter, locks onto the
// increment sequence and flags every sample that breaks it.
module cnt_seq_checker #(
  parameter int WIDTH    = 3,
  parameter int SYNC_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] cnt_i,
  output logic             locked_o,
  output logic             err_pulse_o,
  output logic [ERR_W-1:0] err_cnt_o,
  output logic [WIDTH-1:0] last_bad_o,
  output logic [WIDTH-1:0] exp_o,
  output logic [1:0]       state_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SYNC = 2'd1,
    S_LOCK = 2'd2
  } state_t;

  localparam logic [3:0]       SYNC_V  = 4'(SYNC_CNT);
  localparam logic [ERR_W-1:0] ERR_MAX = '1;

  state_t           r_state;
  logic [WIDTH-1:0] r_prev;
  logic [3:0]       r_run;
  logic [WIDTH-1:0] r_exp;
  logic             r_locked;
  logic             r_pulse;
  logic [ERR_W-1:0] r_err_cnt;
  logic [WIDTH-1:0] r_last_bad;

  logic [WIDTH-1:0] w_cnt_inc;
  logic [3:0]       w_run_next;
  logic [ERR_W-1:0] w_err_next;

  // run only ever climbs to SYNC_CNT before leaving SYNC, so 4 bits never wrap.
  always_comb begin
    w_cnt_inc  = cnt_i + WIDTH'(1);
    w_run_next = (cnt_i == r_prev + WIDTH'(1)) ? r_run + 4'd1 : 4'd0;
    w_err_next = r_err_cnt;
    if (clr_i)
      w_err_next = ERR_W'(1);
    else if (r_err_cnt != ERR_MAX)
      w_err_next = r_err_cnt + ERR_W'(1);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_prev     <= '0;
      r_run      <= '0;
      r_exp      <= '0;
      r_locked   <= 1'b0;
      r_pulse    <= 1'b0;
      r_err_cnt  <= '0;
      r_last_bad <= '0;
    end else begin
      r_pulse <= 1'b0;
      if (clr_i)
        r_err_cnt <= '0;
      if (!en) begin
        // Disable wins over any mismatch on the same edge.
        r_state  <= S_IDLE;
        r_locked <= 1'b0;
      end else begin
        case (r_state)
          S_IDLE: begin
            r_prev  <= cnt_i;
            r_run   <= '0;
            r_state <= S_SYNC;
          end
          S_SYNC: begin
            r_prev <= cnt_i;
            r_run  <= w_run_next;
            if (w_run_next == SYNC_V) begin
              r_state  <= S_LOCK;
              r_locked <= 1'b1;
              r_exp    <= w_cnt_inc;
            end
          end
          S_LOCK: begin
            if (cnt_i == r_exp) begin
              r_exp <= w_cnt_inc;
            end else begin
              // The bad value becomes the seed for reacquiring lock.
              r_pulse    <= 1'b1;
              r_err_cnt  <= w_err_next;
              r_last_bad <= cnt_i;
              r_prev     <= cnt_i;
              r_run      <= '0;
              r_state    <= S_SYNC;
              r_locked   <= 1'b0;
            end
          end
          default: begin
            r_state  <= S_IDLE;
            r_locked <= 1'b0;
          end
        endcase
      end
    end
  end

  assign locked_o    = r_locked;
  assign err_pulse_o = r_pulse;
  assign err_cnt_o   = r_err_cnt;
  assign last_bad_o  = r_last_bad;
  assign exp_o       = r_exp;
  assign state_o     = r_state;

endmodule

// File: tb/tb_cnt_seq_checker.sv
// Bench for cnt_seq_checker: directed test-plan scenarios then random
// streams, checked through an expected-output queue against a reference model.
module tb_cnt_seq_checker;

  localparam int WIDTH = 3;
  localparam int SYNC  = 2;
  localparam int ERR_W = 2;
  localparam int MODN  = 1 << WIDTH;
  localparam int EMAX  = (1 << ERR_W) - 1;
  localparam int W     = 2 + ERR_W + 2 * WIDTH;

  logic             clk;
  logic             rstn;
  logic             en;
  logic             clr_i;
  logic [WIDTH-1:0] cnt_i;
  logic             locked_o;
  logic             err_pulse_o;
  logic [ERR_W-1:0] err_cnt_o;
  logic [WIDTH-1:0] last_bad_o;
  logic [WIDTH-1:0] exp_o;
  logic [1:0]       state_o;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  cnt_seq_checker #(.WIDTH(WIDTH), .SYNC_CNT(SYNC), .ERR_W(ERR_W)) dut (
    .clk(clk), .rstn(rstn), .en(en), .clr_i(clr_i), .cnt_i(cnt_i),
    .locked_o(locked_o), .err_pulse_o(err_pulse_o), .err_cnt_o(err_cnt_o),
    .last_bad_o(last_bad_o), .exp_o(exp_o), .state_o(state_o)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // ---------------- reference model ----------------
  // Mode: 0 = disabled/idle, 1 = hunting for lock, 2 = locked.
  int m_mode, m_prev, m_run, m_next, m_err, m_bad, m_pulse;

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_run = 0; m_next = 0;
    m_err = 0; m_bad = 0; m_pulse = 0;
  endtask

  task automatic model_step(input bit e, input bit c, input int v);
    m_pulse = 0;
    if (c) m_err = 0;
    if (!e) begin
      m_mode = 0;
    end else if (m_mode == 0) begin
      m_prev = v; m_run = 0; m_mode = 1;
    end else if (m_mode == 1) begin
      m_run  = (v == (m_prev + 1) % MODN) ? m_run + 1 : 0;
      m_prev = v;
      if (m_run == SYNC) begin
        m_mode = 2;
        m_next = (v + 1) % MODN;
      end
    end else if (v == m_next) begin
      m_next = (v + 1) % MODN;
    end else begin
      m_pulse = 1;
      m_err   = c ? 1 : ((m_err < EMAX) ? m_err + 1 : EMAX);
      m_bad   = v; m_prev = v; m_run = 0; m_mode = 1;
    end
  endtask

  function automatic logic [W-1:0] model_pack();
    logic [W-1:0] p;
    p = {(m_mode == 2) ? 1'b1 : 1'b0, m_pulse[0], ERR_W'(m_err),
         WIDTH'(m_bad), WIDTH'(m_next)};
    return p;
  endfunction

  function automatic logic [W-1:0] dut_pack();
    logic [W-1:0] p;
    p = {locked_o, err_pulse_o, err_cnt_o, last_bad_o, exp_o};
    return p;
  endfunction

  // ---------------- driver ----------------
  int cv;

  task automatic step(input bit e, input bit c, input int v);
    @(negedge clk);
    en = e; clr_i = c; cnt_i = WIDTH'(v);
    model_step(e, c, v);
    exp_q.push_back(model_pack());
  endtask

  task automatic run_clean(input int n);
    for (int i = 0; i < n; i++) begin
      cv = (cv + 1) % MODN;
      step(1'b1, 1'b0, cv);
    end
  endtask

  task automatic fault(input int skip);
    cv = (cv + skip) % MODN;
    step(1'b1, 1'b0, cv);
  endtask

  task automatic wait_lock_exp(input int want);
    for (int i = 0; i < 3 * MODN && !(m_mode == 2 && m_next == want); i++)
      run_clean(1);
  endtask

  // ---------------- monitor / scoreboard ----------------
  initial begin
    logic [W-1:0] e;
    logic [W-1:0] a;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        a = dut_pack();
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got lock=%0b pulse=%0b err=%0d bad=%0d exp=%0d want lock=%0b pulse=%0b err=%0d bad=%0d exp=%0d",
                   $time, a[W-1], a[W-2], a[2*WIDTH+:ERR_W], a[WIDTH+:WIDTH], a[WIDTH-1:0],
                   e[W-1], e[W-2], e[2*WIDTH+:ERR_W], e[WIDTH+:WIDTH], e[WIDTH-1:0]);
        end
      end
    end
  end

  task automatic check_zero(input string name);
    checks++;
    if (dut_pack() !== '0 || state_o !== 2'd0) begin
      errors++;
      $display("FAIL %s got outputs=%h state=%0d want outputs=0 state=0", name, dut_pack(), state_o);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rstn = 1'b0; en = 1'b0; clr_i = 1'b0; cnt_i = '0;
    model_reset();
    #50;
    check_zero("reset_state");
    #50;
    rstn = 1'b1;

    // Clean lock from 0, then two full wraps.
    cv = 0;
    step(1'b1, 1'b0, 0);
    run_clean(2 * MODN + 3);

    // Single skip fault while expecting 4, then relock.
    wait_lock_exp(4);
    fault(2);
    run_clean(4);

    // Stuck counter at 3 for four edges.
    wait_lock_exp(3);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 3);
    cv = 3;
    run_clean(4);

    // Saturation: clear, then five separated faults.
    cv = (cv + 1) % MODN;
    step(1'b1, 1'b1, cv);
    for (int i = 0; i < 5; i++) begin
      fault(2);
      run_clean(4);
    end
    // Clear coinciding with a mismatch, then clear alone.
    cv = (cv + 3) % MODN;
    step(1'b1, 1'b1, cv);
    run_clean(4);
    cv = (cv + 1) % MODN;
    step(1'b1, 1'b1, cv);
    run_clean(2);

    // Enable drop while locked with a jump on the input.
    cv = (cv + 5) % MODN;
    step(1'b0, 1'b0, cv);
    step(1'b0, 1'b0, cv);
    run_clean(4);

    // Two faults, then asynchronous reset mid-run.
    fault(3); run_clean(3);
    fault(3); run_clean(3);
    @(negedge clk);
    #5 rstn = 1'b0;
    #1 check_zero("async_reset");
    @(negedge clk);
    rstn = 1'b1;
    model_reset();
    step(1'b0, 1'b0, 0);
    cv = 0;
    step(1'b1, 1'b0, 0);
    run_clean(4);

    // Random streams: mostly incrementing with holds, skips, disables, clears.
    for (int i = 0; i < 500; i++) begin
      int r;
      r = $urandom_range(0, 99);
      if (r < 8)       cv = $urandom_range(0, MODN - 1);
      else if (r < 12) cv = cv;
      else             cv = (cv + 1) % MODN;
      step(($urandom_range(0, 19) != 0), ($urandom_range(0, 24) == 0), cv);
    end

    repeat (3) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    errors++;
    $display("FAIL timeout got no finish want finish before 1ms");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
